// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;
   localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not own the previous grant.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last_owner,
   output logic [1:0] gnt
);
   for (genvar gi = 0; gi < 2; gi++) begin : g_pick
      localparam int     OTHER = 1 - gi;
      localparam owner_t ME    = (gi == 0) ? OWN_IF : OWN_DM;
      assign gnt[gi] = req[gi] & (~req[OTHER] | (last_owner != ME));
   end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port,
// one outstanding transaction at a time, with a wait-cycle timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_done,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_gnt,
   output logic                  dm_done,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   owner_t                last_owner_q, last_owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  we_q, we_d;
   logic                  if_done_q, if_done_d;
   logic                  dm_done_q, dm_done_d;
   logic                  err_q, err_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [1:0]            pick;
   logic                  grant_ok, ack_hit, timeout_hit;

   arb_rr2 u_arb (
      .req       ({dm_req, if_req}),
      .last_owner(last_owner_q),
      .gnt       (pick)
   );

   assign grant_ok    = (state_q == IDLE) && !rst && (|pick);
   assign ack_hit     = (state_q == BUSY) && mem_ack;
   // An ack in the final wait cycle completes normally instead of aborting.
   assign timeout_hit = (state_q == BUSY) && !mem_ack && (wait_q == WAIT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (grant_ok) state_d = BUSY;
         BUSY: if (ack_hit || timeout_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q == BUSY);
      mem_req = (state_q == BUSY);
      if_gnt  = grant_ok && pick[0];
      dm_gnt  = grant_ok && pick[1];
   end

   always_comb begin
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      wait_d       = wait_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      if_done_d    = 1'b0;
      dm_done_d    = 1'b0;
      err_d        = 1'b0;
      if (grant_ok) begin
         owner_d      = pick[1] ? OWN_DM : OWN_IF;
         last_owner_d = pick[1] ? OWN_DM : OWN_IF;
         addr_d       = pick[1] ? dm_addr : if_addr;
         wdata_d      = pick[1] ? dm_wdata : '0;
         we_d         = pick[1] & dm_we;
         wait_d       = '0;
      end else if (ack_hit || timeout_hit) begin
         if_done_d = (owner_q == OWN_IF);
         dm_done_d = (owner_q == OWN_DM);
         err_d     = timeout_hit;
         if (ack_hit && !we_q) begin
            if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
            else                   dm_rdata_d = mem_rdata;
         end
      end else if (state_q == BUSY) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_DM;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         wait_q       <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         if_done_q    <= 1'b0;
         dm_done_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         wait_q       <= wait_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
         if_done_q    <= if_done_d;
         dm_done_q    <= dm_done_d;
         err_q        <= err_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = busy & we_q;
   assign if_done   = if_done_q;
   assign dm_done   = dm_done_q;
   assign err       = err_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of all data buses.
REQ-002 Parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-003 Parameter TIMEOUT, default 255, maximum number of BUSY cycles to wait for mem_ack before aborting.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high; the ports are named clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 if_req  in  1  fetch-port request; held high until if_gnt.
REQ-008 if_addr  in  ADDR_WIDTH  fetch address (PC).
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_done  out  1  one-cycle pulse: fetch complete.
REQ-011 if_rdata  out  DATA_WIDTH  fetched instruction.
REQ-012 dm_req / dm_we  in  1 / 1  data-port request and write flag; dm_req held high until dm_gnt.
REQ-013 dm_addr / dm_wdata  in  ADDR_WIDTH / DATA_WIDTH  data-port address and write data.
REQ-014 dm_gnt / dm_done  out  1 / 1  data-port accept and completion pulse.
REQ-015 dm_rdata  out  DATA_WIDTH  load data.
REQ-016 err  out  1  one-cycle pulse, coincident with done, on timeout abort.
REQ-017 mem_req / mem_we  out  1 / 1  shared-memory request and write enable.
REQ-018 mem_addr / mem_wdata  out  ADDR_WIDTH / DATA_WIDTH  shared-memory address and write data.
REQ-019 mem_ack / mem_rdata  in  1 / DATA_WIDTH  memory completion and read data, valid in the mem_ack cycle.
REQ-020 busy  out  1  high while the FSM is not IDLE.

Function
REQ-021 The FSM SHALL have two states, IDLE and BUSY, and SHALL allow exactly one outstanding transaction.
REQ-022 In IDLE with at least one request, the block SHALL assert the gnt of the selected requester combinationally in the same cycle, capture that requester's addr/we/wdata, and enter BUSY on the next clock edge.
REQ-023 Arbitration SHALL be two-way round-robin: a single requester wins; if both request, the requester that was not last_owner wins; last_owner updates on every grant.
REQ-024 Fetch transactions SHALL always drive mem_we=0, whatever the data-port inputs are.
REQ-025 In BUSY, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL hold the captured values until mem_ack.
REQ-026 On mem_ack in BUSY, the FSM SHALL return to IDLE on the next edge; in that cycle the owner's done SHALL pulse high, and for reads its rdata SHALL take the registered mem_rdata.
REQ-027 rdata SHALL hold its value otherwise, including across writes.
REQ-028 A new grant is permitted in the same cycle the done pulses, giving a minimum request-to-done latency of 2 cycles and a peak rate of 1 transaction per 2 cycles.
REQ-029 mem_ack in IDLE SHALL be ignored.
REQ-030 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-031 When the wait counter reaches TIMEOUT, the FSM SHALL abort to IDLE, pulse the owner's done together with err, and leave rdata unchanged.
REQ-032 mem_ack arriving in the same cycle as the timeout SHALL win: the transaction completes normally and err stays 0.
REQ-033 No gnt SHALL be asserted while busy=1.

Reset
REQ-034 While rst=1, the FSM SHALL be IDLE, and mem_req, all gnt, done and err outputs, busy, and the wait counter SHALL be 0.
REQ-035 While rst=1, if_rdata, dm_rdata and the captured addr/wdata registers SHALL be 0, and last_owner SHALL be data, so fetch wins the first contested cycle.
REQ-036 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously), and the pending done SHALL never be issued.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY), the owner enum (OWN_IF, OWN_DM), and the default TIMEOUT constant.
REQ-038 The round-robin pick SHALL be a sub-module named arb_rr2 (inputs: two requests and last_owner; outputs: one-hot grant), instantiated once.

Verification
REQ-039 Fetch alone: if_req=1, if_addr=0x0000_0004, mem_ack one cycle after mem_req with mem_rdata=0x0050_0093 -> if_gnt in cycle 0, mem_req in cycle 1, if_done in cycle 2, and if_rdata=0x0050_0093.
REQ-040 Contention after reset: if_req=dm_req=1 continuously with zero-wait ack -> grants alternate IF, DM, IF, DM, and each requester gets one done per 4 cycles.
REQ-041 Data write: dm_we=1, dm_addr=0x0001_0000, dm_wdata=0xDEAD_BEEF -> mem_we=1 with those values held until mem_ack, dm_done pulses, and dm_rdata is unchanged.
REQ-042 Timeout: TIMEOUT=4 with no mem_ack -> mem_req high for exactly 4 cycles, then done=1 and err=1 in the same cycle, and busy=0 next.
REQ-043 Reset mid-BUSY: rst pulsed while mem_req=1 -> mem_req=0 immediately, no done pulse, and fetch wins the next contested cycle.
